// File: rtl/safety_wdt_kick_ctrl.sv
// rtl/safety_wdt_kick_ctrl.sv - Epoch check-in scheduler that gates safety watchdog kicks
module safety_wdt_kick_ctrl #(
  parameter int NUM_REQ    = 4,
  parameter int TOKEN_W    = 8,
  parameter int PERIOD_CYC = 4096,
  parameter int MAX_MISS   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*TOKEN_W-1:0] req_token_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [TOKEN_W-1:0]         epoch_o,
  output logic [NUM_REQ-1:0]         checkin_mask_o,
  output logic                       kick_o,
  input  logic                       wdt_timeout_i,
  output logic [3:0]                 miss_cnt_o,
  output logic                       fault_o,
  output logic [1:0]                 fault_code_o,
  output logic [NUM_REQ-1:0]         fault_src_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(PERIOD_CYC - 1);
  localparam logic [3:0]         MISS_LIMIT = 4'(MAX_MISS);
  localparam logic [NUM_REQ-1:0] ALL_IN     = {NUM_REQ{1'b1}};
  localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_REQ - 1);

  localparam logic [1:0] CODE_NONE = 2'd0;
  localparam logic [1:0] CODE_BAD  = 2'd1;
  localparam logic [1:0] CODE_MISS = 2'd2;
  localparam logic [1:0] CODE_WDT  = 2'd3;

  typedef enum logic [1:0] {COLLECT, KICK, FAULT} state_t;

  state_t             state_q, state_d;
  logic [TOKEN_W-1:0] epoch_q, epoch_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [3:0]         miss_q, miss_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [1:0]         code_q, code_d;
  logic [NUM_REQ-1:0] src_q, src_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic [TOKEN_W-1:0] grant_token;
  logic               token_ok;
  logic [NUM_REQ-1:0] mask_acc;
  logic [3:0]         miss_inc;

  // Round-robin search starting at ptr_q; first valid requester wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant       = '0;
    grant_idx   = '0;
    grant_any   = 1'b0;
    grant_token = '0;
    if (state_q == COLLECT) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(ptr_q) + i) % NUM_REQ;
        if (!grant_any && req_valid_i[idx]) begin
          grant_any   = 1'b1;
          grant[idx]  = 1'b1;
          grant_idx   = PTR_W'(idx);
          grant_token = req_token_i[idx*TOKEN_W +: TOKEN_W];
        end
      end
    end
  end

  assign token_ok = (grant_token == epoch_q);

  always_comb begin
    state_d  = state_q;
    epoch_d  = epoch_q;
    mask_d   = mask_q;
    timer_d  = timer_q;
    miss_d   = miss_q;
    ptr_d    = ptr_q;
    code_d   = code_q;
    src_d    = src_q;
    mask_acc = mask_q | ((grant_any && token_ok) ? grant : '0);
    miss_inc = (miss_q == 4'hF) ? 4'hF : miss_q + 4'd1;

    case (state_q)
      COLLECT: begin
        if (grant_any) begin
          ptr_d = (grant_idx == PTR_LAST) ? '0 : grant_idx + PTR_W'(1);
        end
        if (wdt_timeout_i) begin
          state_d = FAULT;
          code_d  = CODE_WDT;
          src_d   = '0;
        end else if (grant_any && !token_ok) begin
          state_d = FAULT;
          code_d  = CODE_BAD;
          src_d   = grant;
        end else if (mask_acc == ALL_IN) begin
          // Completion beats expiry, so a last check-in on the final cycle still kicks.
          state_d = KICK;
          mask_d  = mask_acc;
        end else if (timer_q == TMR_LAST) begin
          miss_d  = miss_inc;
          timer_d = '0;
          mask_d  = '0;
          if (miss_inc >= MISS_LIMIT) begin
            state_d = FAULT;
            code_d  = CODE_MISS;
            src_d   = ~mask_acc;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
          mask_d  = mask_acc;
        end
      end
      KICK: begin
        if (wdt_timeout_i) begin
          state_d = FAULT;
          code_d  = CODE_WDT;
          src_d   = '0;
        end else begin
          state_d = COLLECT;
          epoch_d = epoch_q + TOKEN_W'(1);
          mask_d  = '0;
          timer_d = '0;
          miss_d  = '0;
        end
      end
      FAULT: begin
        // Everything held for post-mortem; only reset leaves this state.
        state_d = FAULT;
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= COLLECT;
      epoch_q <= '0;
      mask_q  <= '0;
      timer_q <= '0;
      miss_q  <= '0;
      ptr_q   <= '0;
      code_q  <= CODE_NONE;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      epoch_q <= epoch_d;
      mask_q  <= mask_d;
      timer_q <= timer_d;
      miss_q  <= miss_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      src_q   <= src_d;
    end
  end

  assign req_ready_o    = grant;
  assign epoch_o        = epoch_q;
  assign checkin_mask_o = mask_q;
  assign kick_o         = (state_q == KICK);
  assign miss_cnt_o     = miss_q;
  assign fault_o        = (state_q == FAULT);
  assign fault_code_o   = code_q;
  assign fault_src_o    = src_q;

endmodule
